// File: rtl/uart_pkg.sv
// uart_pkg: state encoding, byte width and default watchdog limit shared by the UART TX arbiter
package uart_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        COMPLETE  = 3'd4
    } uart_tx_arb_state_t;
    localparam int UART_BYTE_W = 8;
    localparam int TIMEOUT_CYC_DEF = 65535;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning upward from the slot after i_ptr
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]        i_req,
    input  logic [idx_w(NUM_REQ)-1:0] i_ptr,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic [idx_w(NUM_REQ)-1:0] o_idx,
    output logic                      o_any
);
    localparam int IW = idx_w(NUM_REQ);
    logic          w_found;
    logic [IW-1:0] w_j;
    always_comb begin
        o_grant = '0;
        o_idx = '0;
        w_found = 1'b0;
        w_j = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_j = IW'((int'(i_ptr) + i) % NUM_REQ);
            if (!w_found && i_req[w_j]) begin
                w_found = 1'b1;
                o_idx = w_j;
                o_grant[w_j] = 1'b1;
            end
        end
    end
    assign o_any = |i_req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin share of one UART transmitter, each granted word sent LSB byte first
// Define UART_TX_ARB_TIMEOUT_EN to add a WAIT_DONE watchdog that abandons a stalled word and pulses err_out
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W = 32,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        req_done,
    input  logic                      txDone,
    input  logic                      busy,
    output logic                      tx_en,
    output logic                      txStart,
    output logic [UART_BYTE_W-1:0]    txData,
    output logic [idx_w(NUM_REQ)-1:0] grant_id,
    output logic                      active,
    output logic                      err_out
);
    localparam int BYTES = DATA_W / UART_BYTE_W;
    localparam int IW = idx_w(NUM_REQ);
    localparam int BW = idx_w(BYTES);

    uart_tx_arb_state_t   r_state, w_state_n;
    logic [DATA_W-1:0]    r_shift, w_shift_n;
    logic [BW-1:0]        r_cnt, w_cnt_n;
    logic [IW-1:0]        r_ptr, w_ptr_n, w_gid, w_gid_n;
    logic [NUM_REQ-1:0]   w_grant, w_ready_n, w_done_n;
    logic                 w_any, w_start_n;
    logic [UART_BYTE_W-1:0] w_txdata_n;
`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0]          r_wdog, w_wdog_n;
    logic                 w_err_n;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .i_req  (req_valid),
        .i_ptr  (r_ptr),
        .o_grant(w_grant),
        .o_idx  (w_gid),
        .o_any  (w_any)
    );

    always_comb begin
        w_state_n = r_state;
        w_shift_n = r_shift;
        w_cnt_n = r_cnt;
        w_ptr_n = r_ptr;
        w_gid_n = grant_id;
        w_ready_n = '0;
        w_done_n = '0;
        w_start_n = 1'b0;
        w_txdata_n = txData;
`ifdef UART_TX_ARB_TIMEOUT_EN
        w_wdog_n = r_wdog;
        w_err_n = 1'b0;
`endif
        case (r_state)
            IDLE: if (w_any) begin
                w_state_n = LOAD;
                w_shift_n = req_data[int'(w_gid)*DATA_W +: DATA_W];
                w_gid_n = w_gid;
                w_ready_n = w_grant;
                w_cnt_n = '0;
            end
            LOAD: begin
                w_txdata_n = r_shift[UART_BYTE_W-1:0];
                w_state_n = START;
            end
            START: if (!busy) begin
                w_start_n = 1'b1;
                w_state_n = WAIT_DONE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                w_wdog_n = '0;
`endif
            end
            // txDone wins over busy and over the watchdog in the same cycle
            WAIT_DONE: if (txDone) begin
                if (r_cnt == BW'(BYTES - 1))
                    w_state_n = COMPLETE;
                else begin
                    w_shift_n = r_shift >> UART_BYTE_W;
                    w_cnt_n = r_cnt + BW'(1);
                    w_state_n = LOAD;
                end
            end
`ifdef UART_TX_ARB_TIMEOUT_EN
            else if (r_wdog == 16'(TIMEOUT_CYC - 1)) begin
                w_err_n = 1'b1;
                w_ptr_n = grant_id;
                w_state_n = IDLE;
            end else
                w_wdog_n = r_wdog + 16'd1;
`endif
            COMPLETE: begin
                w_done_n[grant_id] = 1'b1;
                w_ptr_n = grant_id;
                w_state_n = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt <= '0;
            r_ptr <= IW'(NUM_REQ - 1);
            grant_id <= '0;
            req_ready <= '0;
            req_done <= '0;
            txStart <= 1'b0;
            txData <= '0;
            active <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_shift <= w_shift_n;
            r_cnt <= w_cnt_n;
            r_ptr <= w_ptr_n;
            grant_id <= w_gid_n;
            req_ready <= w_ready_n;
            req_done <= w_done_n;
            txStart <= w_start_n;
            txData <= w_txdata_n;
            active <= (w_state_n != IDLE);
        end
    end

    assign tx_en = active;

`ifdef UART_TX_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wdog <= '0;
            err_out <= 1'b0;
        end else begin
            r_wdog <= w_wdog_n;
            err_out <= w_err_n;
        end
    end
`else
    assign err_out = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven word transfers plus busy, reset and timeout sequences for uart_tx_arbiter
module tb_uart_tx_arbiter;
    logic        clk, rst;
    logic [1:0]  req_valid, req_ready, req_done;
    logic [63:0] req_data;
    logic        txDone, busy, tx_en, txStart, active, err_out;
    logic [7:0]  txData;
    logic [0:0]  grant_id;

    int checks = 0, failures = 0;
    int n_start = 0, n_done = 0, n_err = 0;
    int exp_start = 0, exp_done = 0;

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] d0;
        logic [31:0] d1;
        int          k;
        bit          spur;
        int          gid;
        logic [31:0] word;
    } vec_t;
    vec_t tbl[8];

    uart_tx_arbiter #(.NUM_REQ(2), .DATA_W(32), .TIMEOUT_CYC(20)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_data (req_data),
        .req_ready(req_ready),
        .req_done (req_done),
        .txDone   (txDone),
        .busy     (busy),
        .tx_en    (tx_en),
        .txStart  (txStart),
        .txData   (txData),
        .grant_id (grant_id),
        .active   (active),
        .err_out  (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (txStart) n_start++;
        if (|req_done) n_done++;
        if (err_out) n_err++;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // sel: 0 = req_ready, 1 = txStart, 2 = req_done
    task automatic wait_for(input int sel, output int t);
        t = 0;
        do begin
            tick;
            txDone = 1'b0;
            t++;
        end while (!(sel == 0 ? |req_ready : sel == 1 ? txStart : |req_done) && t < 40);
        if (t >= 40) begin
            checks++;
            failures++;
            $display("FAIL wait_sel%0d actual=expired required=event", sel);
        end
    endtask

    // first txStart already seen at the current sample point
    task automatic bytes(input int k, input int gid, output logic [31:0] w);
        int t;
        for (int b = 0; b < 4; b++) begin
            if (b > 0) begin
                wait_for(1, t);
                chk($sformatf("byte%0d_lat", b), t, 2);
            end
            w[8*b +: 8] = txData;
            chk($sformatf("byte%0d_gid", b), grant_id, gid);
            repeat (k) tick;
            txDone = 1'b1;
            tick;
            txDone = 1'b0;
        end
    endtask

    task automatic run_row(input vec_t v, input string nm);
        int t, s0;
        logic [31:0] w;
        if (v.spur) begin
            req_valid = '0;
            txDone = 1'b1;
            tick;
            txDone = 1'b0;
        end
        req_valid = v.valid;
        req_data = {v.d1, v.d0};
        s0 = n_start;
        wait_for(0, t);
        chk({nm, "_ready"}, req_ready, 2'b01 << v.gid);
        chk({nm, "_gid"}, grant_id, v.gid);
        chk({nm, "_txen"}, tx_en, 1);
        req_data = ~req_data;
        if (v.spur) txDone = 1'b1;
        wait_for(1, t);
        chk({nm, "_lat0"}, t, 2);
        bytes(v.k, v.gid, w);
        wait_for(2, t);
        chk({nm, "_done"}, req_done, 2'b01 << v.gid);
        chk({nm, "_word"}, w, v.word);
        chk({nm, "_starts"}, n_start - s0, 4);
        chk({nm, "_idle"}, active, 0);
        exp_start += 4;
        exp_done += 1;
    endtask

    initial begin
        int t, d;
        logic [31:0] w;
        vec_t fresh;
        tbl[0] = '{2'b11, 32'h11111111, 32'h22222222, 5, 1'b0, 0, 32'h11111111};
        tbl[1] = '{2'b11, 32'h11111111, 32'h22222222, 5, 1'b0, 1, 32'h22222222};
        tbl[2] = '{2'b11, 32'h11111111, 32'h22222222, 3, 1'b0, 0, 32'h11111111};
        tbl[3] = '{2'b11, 32'h11111111, 32'h22222222, 3, 1'b0, 1, 32'h22222222};
        tbl[4] = '{2'b01, 32'hA1B2C3D4, 32'h00000000, 5, 1'b1, 0, 32'hA1B2C3D4};
        tbl[5] = '{2'b10, 32'h00000000, 32'hCAFEBABE, 1, 1'b0, 1, 32'hCAFEBABE};
        tbl[6] = '{2'b01, 32'h12345678, 32'h00000000, 0, 1'b1, 0, 32'h12345678};
        tbl[7] = '{2'b11, 32'h0BADF00D, 32'h89ABCDEF, 2, 1'b0, 1, 32'h89ABCDEF};

        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        txDone = 1'b0;
        busy = 1'b0;
        repeat (3) tick;
        chk("rst_ready", req_ready, 0);
        chk("rst_done", req_done, 0);
        chk("rst_txen", tx_en, 0);
        chk("rst_start", txStart, 0);
        chk("rst_data", txData, 0);
        chk("rst_gid", grant_id, 0);
        chk("rst_active", active, 0);
        chk("rst_err", err_out, 0);
        rst = 1'b0;
        tick;

        for (int i = 0; i < 8; i++) run_row(tbl[i], $sformatf("row%0d", i));
        req_valid = '0;

        // busy held for 10 cycles of START
        req_valid = 2'b01;
        req_data = {32'h0, 32'h55AA33CC};
        wait_for(0, t);
        req_valid = '0;
        busy = 1'b1;
        tick;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("busy_hold%0d", i), {txStart, txData}, {1'b0, 8'hCC});
            if (i == 9) busy = 1'b0;
            tick;
        end
        chk("busy_release", {txStart, txData}, {1'b1, 8'hCC});
        bytes(2, 0, w);
        wait_for(2, t);
        chk("busy_word", w, 32'h55AA33CC);
        chk("busy_done", req_done, 2'b01);
        exp_start += 4;
        exp_done += 1;

        // reset after the second byte has started
        req_valid = 2'b10;
        req_data = {32'hDEADBEEF, 32'h0};
        wait_for(0, t);
        req_valid = '0;
        wait_for(1, t);
        chk("mid_b0", txData, 8'hEF);
        tick;
        txDone = 1'b1;
        tick;
        txDone = 1'b0;
        wait_for(1, t);
        chk("mid_b1", txData, 8'hBE);
        d = n_done;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_ready", req_ready, 0);
        chk("mid_txen", tx_en, 0);
        chk("mid_start", txStart, 0);
        chk("mid_data", txData, 0);
        chk("mid_gid", grant_id, 0);
        chk("mid_active", active, 0);
        repeat (8) tick;
        chk("mid_nodone", n_done, d);
        exp_start += 2;
        fresh = '{2'b10, 32'h0, 32'h0F1E2D3C, 1, 1'b0, 1, 32'h0F1E2D3C};
        run_row(fresh, "fresh");
        req_valid = '0;

`ifdef UART_TX_ARB_TIMEOUT_EN
        req_valid = 2'b01;
        req_data = {32'h9A9A5C5C, 32'h13572468};
        wait_for(0, t);
        chk("to_gid0", grant_id, 0);
        req_valid = 2'b11;
        wait_for(1, t);
        d = n_done;
        t = 0;
        while (!err_out && t < 40) begin
            tick;
            t++;
        end
        chk("to_lat", t, 20);
        chk("to_idle", active, 0);
        tick;
        chk("to_err_pulse", err_out, 0);
        chk("to_next_ready", req_ready, 2'b10);
        chk("to_next_gid", grant_id, 1);
        chk("to_nodone", n_done, d);
        req_valid = '0;
        wait_for(1, t);
        bytes(1, 1, w);
        wait_for(2, t);
        chk("to_next_word", w, 32'h9A9A5C5C);
        chk("to_next_done", req_done, 2'b10);
        exp_start += 5;
        exp_done += 1;
`endif

        repeat (3) tick;
        chk("total_starts", n_start, exp_start);
        chk("total_dones", n_done, exp_done);
`ifdef UART_TX_ARB_TIMEOUT_EN
        chk("total_errs", n_err, 1);
`else
        chk("total_errs", n_err, 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares the single UART transmitter between NUM_REQ requesters, e.g. the APB/UART interface and the GPIO event reporter. Accepts one DATA_W-bit word per grant and serialises it to the transmitter byte by byte, least-significant byte first. Sequencing uses the transmitter's start/done/busy handshake. Requesters are granted in round-robin order.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
DATA_W, 32, word width; must be a multiple of 8; BYTES = DATA_W/8
TIMEOUT_CYC, 65535, watchdog limit in WAIT_DONE (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  requester i has a word pending
req_data  in  NUM_REQ*DATA_W  word of requester i, at bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  one-cycle pulse: word of requester i accepted
req_done  out  NUM_REQ  one-cycle pulse: all bytes of requester i's word sent
txDone  in  1  transmitter finished the current byte (pulse)
busy  in  1  transmitter busy; no start is issued while high
tx_en  out  1  transmitter enable; high from LOAD through COMPLETE
txStart  out  1  one-cycle start pulse to the transmitter
txData  out  8  byte presented to the transmitter
grant_id  out  clog2(NUM_REQ)  index of the current owner; valid while active is high
active  out  1  high whenever state is not IDLE
err_out  out  1  one-cycle timeout pulse (optional feature only; otherwise tied 0)

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, req_done=0, tx_en=0, txStart=0, txData=0, grant_id=0, active=0, err_out=0. Internal state: rr_ptr=NUM_REQ-1, byte_cnt=0, state=IDLE.
- States: IDLE, LOAD, START, WAIT_DONE, COMPLETE.
- IDLE, arbitration:
  - Scan req_valid from rr_ptr+1 upward, wrapping modulo NUM_REQ; the first set bit wins.
  - On the edge, the winning word is latched into shift_reg, grant_id is set, req_ready[g] pulses for exactly one cycle, byte_cnt=0, and the FSM moves to LOAD.
  - If no req_valid bit is set, the FSM stays in IDLE.
- LOAD: txData <= shift_reg[7:0]; move to START.
- START:
  - If busy=0: txStart=1 for one cycle, move to WAIT_DONE.
  - If busy=1: hold in START with txStart=0.
- WAIT_DONE:
  - txDone is sampled only in this state; a txDone in any other state is ignored.
  - On txDone with byte_cnt==BYTES-1: move to COMPLETE.
  - On txDone otherwise: shift_reg >>= 8, byte_cnt++, move to LOAD.
- COMPLETE: req_done[g] pulses for one cycle, rr_ptr <= g, move to IDLE.
- Latency, with busy=0 and txDone arriving k cycles after txStart:
  - req_ready pulses 1 cycle after req_valid is seen in IDLE.
  - The first txStart follows req_ready by 2 cycles.
  - Each subsequent byte costs 3+k cycles.
- The word is captured at grant. Changes to req_valid or req_data after grant do not affect the transfer in progress.
- req_valid from other requesters during a transfer is held off; they are arbitrated in the next IDLE.
- Back-to-back: IDLE is occupied for at least one cycle between words, so the same requester is re-granted only if no other requester is valid.
- NUM_REQ=1: requester 0 is always granted; round-robin degenerates cleanly.
- Reset mid-transfer: FSM returns to IDLE the following cycle, all outputs take reset values, and the word in progress is discarded with no req_done.
- A txDone and busy arriving in the same cycle in WAIT_DONE: txDone takes effect.

Optional Feature:
- Macro: UART_TX_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit watchdog counts cycles in WAIT_DONE; it is cleared on entry to that state.
  - On reaching TIMEOUT_CYC without txDone, err_out pulses for one cycle and the FSM goes to IDLE.
  - In that case the word is abandoned: no req_done, and rr_ptr advances to g.
- When not defined: no counter is built, err_out is constant 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding typedef uart_tx_arb_state_t (IDLE=0, LOAD=1, START=2, WAIT_DONE=3, COMPLETE=4)
  - constant UART_BYTE_W=8
  - default TIMEOUT_CYC
- One sub-module: rr_arbiter (NUM_REQ). Purely combinational: takes req and rr_ptr, returns a one-hot grant and the grant index.
- The FSM, shifter and counters stay in uart_tx_arbiter.

Test Plan:
- Single word: req_valid=01, req_data[31:0]=0xA1B2C3D4, txDone 5 cycles after each txStart.
  - Required: txData sequence D4, C3, B2, A1.
  - Exactly 4 txStart pulses.
  - req_done[0] pulses once.
  - grant_id=0 throughout.
- Fairness: both requesters held valid (data 0x11111111 / 0x22222222) for 4 words.
  - Required: grant order 0, 1, 0, 1 (rr_ptr starts at NUM_REQ-1).
  - Each req_ready pulse precedes its word's bytes.
- Busy hold: busy=1 for 10 cycles upon entering START.
  - Required: no txStart while busy is high.
  - txStart is issued the cycle after busy falls; txData is stable throughout.
- Spurious done: txDone pulsed in IDLE and in LOAD.
  - Required: ignored, no byte_cnt advance, byte order unchanged.
- Reset mid-word: rst asserted after the 2nd txStart.
  - Required: next cycle all outputs are 0 and state is IDLE.
  - No req_done.
  - A fresh request restarts at byte 0.
- UART_TX_ARB_TIMEOUT_EN with TIMEOUT_CYC=20, txDone never returned.
  - Required: err_out pulses 20 cycles after WAIT_DONE entry, then IDLE.
  - Another pending requester is granted next.
